uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the debug module.
- Receives a program image over a UART 8N1 serial line and assembles it into 32-bit words.
- Drives the debug load interface (strobe, address, instruction) once per word.
- Asserts start after the last word, handing clock control to the core.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 4.
- ADDR_BASE, 32'h0000_0000, address of the first loaded word.
- MAX_WORDS, 1024, largest accepted word count; a header above this is an error.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- dbg_sig  out  1  one-cycle strobe: dbg_addr and dbg_instr hold a valid word.
- dbg_addr  out  32  load address, ADDR_BASE + 4*index.
- dbg_instr  out  32  assembled little-endian instruction word.
- start  out  1  program fully loaded; sticky until reset.
- busy  out  1  high from the first header byte until DONE or ERR.
- error  out  1  framing or oversize error; sticky until reset.

Behaviour:
- Reset values: dbg_sig=0, dbg_addr=ADDR_BASE, dbg_instr=0, start=0, busy=0, error=0, FSM in S_HDR, byte/word counters 0. Both synchroniser flops reset to 1.
- Reset asserted mid-frame or mid-load: everything aborts to the reset values. The host must resend the full image.
- RX path:
  - 2-flop synchroniser feeds the detector.
  - A falling edge in idle starts a frame.
  - Bit samples are taken at CLKS_PER_BIT/2 into each bit period.
  - Start bit re-checked at its midpoint; if high, the frame is treated as a glitch and ignored with no error.
  - 8 data bits are captured LSB first.
  - Stop bit sampled; if 0, this is a framing error.
  - On a good stop bit: rx_valid pulses 1 cycle with rx_byte. The receiver then waits for the line to be high before re-arming.
- Byte assembly:
  - A 2-bit byte counter selects the lane: byte k goes to bits [8k+7:8k].
  - The word is complete when the counter wraps from 3 to 0.
- FSM:
  - S_HDR: collect 4 bytes as word count N.
    - N > MAX_WORDS -> S_ERR.
    - N = 0 -> S_DONE.
    - Otherwise -> S_DATA with word index = 0.
  - S_DATA: on each completed word:
    - dbg_instr <= word, dbg_addr <= ADDR_BASE + (index<<2), dbg_sig = 1 for exactly the next cycle.
    - index increments.
    - After the Nth word -> S_DONE.
  - S_DONE: start=1 and busy=0. Later UART bytes are ignored.
  - S_ERR: error=1 and busy=0; start is never asserted. Stays here until reset.
  - Framing error in S_HDR or S_DATA -> S_ERR.
- Latency:
  - dbg_sig is high the cycle after the rx_valid of the 4th byte.
  - start rises the cycle after the final dbg_sig, or the cycle after the last header byte when N=0.
- dbg_addr and dbg_instr hold their values between strobes.
- Address arithmetic is 32-bit modulo; wrap past 2^32 is not checked.
- busy rises the cycle after the first rx_valid.

Decomposition:
- loader_pkg:
  - state enum {S_HDR, S_DATA, S_DONE, S_ERR}.
  - rx state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH}.
  - Constant UART_DATA_BITS=8.
- Sub-module uart_rx_byte (parameter CLKS_PER_BIT):
  - Contains the synchroniser, bit timer and shift register.
  - Outputs rx_valid, rx_byte and frame_err.
- uart_prog_loader contains only byte assembly, counters and the load FSM.

Test Plan:
- CLKS_PER_BIT=8. Send header 02 00 00 00, then 13 00 00 00 and 93 00 10 00 -> dbg_sig pulses twice: (0x0, 0x00000013) then (0x4, 0x00100093). start rises 1 cycle after the second pulse; busy falls in the same cycle; error=0.
- Header 00 00 00 00 -> no dbg_sig, start=1 one cycle after the 4th rx_valid.
- Header 01 04 00 00 (N=1025 > MAX_WORDS) -> error=1, start stays 0, and following bytes produce no dbg_sig.
- Word byte with stop bit driven 0 -> error=1, no dbg_sig for that word, start never asserts.
- A 2-cycle low glitch on an idle line -> no rx_valid, no error; the next valid image loads normally.
- nrst pulsed low after 6 of 8 data bytes -> all outputs return to reset values. A full resend then loads correctly from address 0x0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_DONE,
        S_ERR
    } load_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: synchroniser, mid-bit sampling timer and shift register.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      uart_rx,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      sync1_q, sync2_q;
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid  = valid_q;
    assign rx_byte   = shift_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: assembles UART bytes into a word count and program words,
// then strobes each word to the debug load port and raises start.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        uart_rx,
    output logic        dbg_sig,
    output logic [31:0] dbg_addr,
    output logic [31:0] dbg_instr,
    output logic        start,
    output logic        busy,
    output logic        error
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .nrst     (nrst),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .frame_err(frame_err)
    );

    load_state_t state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] count_q, count_d;
    logic [31:0] idx_q, idx_d;
    logic        dbg_sig_q, dbg_sig_d;
    logic [31:0] dbg_addr_q, dbg_addr_d;
    logic [31:0] dbg_instr_q, dbg_instr_d;
    logic        word_done;
    logic [31:0] word_full;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_HDR;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            dbg_sig_q   <= 1'b0;
            dbg_addr_q  <= ADDR_BASE;
            dbg_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            dbg_sig_q   <= dbg_sig_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_instr_q <= dbg_instr_d;
        end
    end

    // The top byte lane is never stored; it completes the word directly.
    assign word_done = rx_valid && (byte_cnt_q == 2'd3);
    assign word_full = {rx_byte, word_q};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        count_d     = count_q;
        idx_d       = idx_q;
        dbg_sig_d   = 1'b0;
        dbg_addr_d  = dbg_addr_q;
        dbg_instr_d = dbg_instr_q;

        if (rx_valid && (state_q == S_HDR || state_q == S_DATA)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (byte_cnt_q == 2'(k)) word_d[8*k +: 8] = rx_byte;
            end
        end

        case (state_q)
            S_HDR: begin
                if (word_done) begin
                    if (word_full > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else if (word_full == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = word_full;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Leave only once the final strobe has been presented.
                if (dbg_sig_q && idx_q == count_q) begin
                    state_d = S_DONE;
                end else if (word_done) begin
                    dbg_sig_d   = 1'b1;
                    dbg_instr_d = word_full;
                    dbg_addr_d  = ADDR_BASE + {idx_q[29:0], 2'b00};
                    idx_d       = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (frame_err && (state_q == S_HDR || state_q == S_DATA)) begin
            state_d   = S_ERR;
            dbg_sig_d = 1'b0;
        end
    end

    assign dbg_sig   = dbg_sig_q;
    assign dbg_addr  = dbg_addr_q;
    assign dbg_instr = dbg_instr_q;
    assign start     = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign busy      = (state_q == S_DATA) || (state_q == S_HDR && byte_cnt_q != 2'd0);

endmodule
